axis_ctrl_rr_arbiter: RTL and testbench

AXIS_CTRL_RR_ARBITER -- requirements
Module: axis_ctrl_rr_arbiter

---
 rtl/axis_ctrl_rr_arbiter.sv | 102 ++++++++++
 tb/tb_axis_ctrl_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ctrl_rr_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS AXI-Stream-style
// requesters onto one output. A grant is taken from IDLE, held for a whole
// packet (until the tlast handshake), then released through one IDLE cycle.
module axis_ctrl_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_PORTS-1:0]           s_axis_tlast,
  input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
  output logic [NUM_PORTS-1:0]           s_axis_tready,
  output logic [WIDTH-1:0]               m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]   grant_idx,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             pkt_done;

  // Round-robin search: first requesting port strictly after last_q, wrapping.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_PORTS);
      if (!found && s_axis_tvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next state: grab a winner from IDLE, release after the tlast handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANTED;
          grant_d = winner;
          last_d  = winner;
        end
      end
      GRANTED: begin
        if (pkt_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: combinational pass-through of the granted port, quiet in IDLE.
  always_comb begin
    m_axis_tdata  = s_axis_tdata[int'(grant_q)*WIDTH +: WIDTH];
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == GRANTED) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
    pkt_done  = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    grant_idx = grant_q;
    busy      = (state_q == GRANTED);
  end

endmodule

// File: tb/tb_axis_ctrl_rr_arbiter.sv
// Directed and randomized bench for axis_ctrl_rr_arbiter (4 ports, 32 bits).
// Each source beat carries {port, packet id, beat index, packet length}.
module tb_axis_ctrl_rr_arbiter;

  localparam int NP = 4;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP*W-1:0] s_tdata;
  logic [NP-1:0] s_tlast, s_tvalid, s_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tlast, m_tvalid, m_tready;
  logic [1:0]    gidx;
  logic          busy;

  always #5 clk = ~clk;

  axis_ctrl_rr_arbiter #(.NUM_PORTS(NP), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .grant_idx(gidx), .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    logic [31:0] d;
    int          c;
    int          g;
  } acc_t;

  int          pq[NP][$];
  int          cur_beat[NP];
  int          pid[NP];
  bit          hold[NP];
  bit          mrdy_dflt;
  int          mrdy_pat[$];
  int          cyc;
  acc_t        acc[$];
  bit          busy_log[$];
  logic        smp_busy, smp_mvalid;
  logic [1:0]  smp_gnt;
  logic [NP-1:0] smp_sready;
  int          viol;
  bit          sb_en;
  int          open_p, open_len, out_beat, nbeats, starve;
  int          out_pid[NP];
  int          sent_pkts[NP];
  int          wait_cnt[NP];
  bit          prev_busy;
  logic [NP-1:0] prev_svalid;
  int          exp_p[$], exp_b[$], exp_c[$];

  function automatic logic [31:0] enc(input int p, input int id, input int b, input int l);
    return {8'(p), 8'(id), 8'(b), 8'(l)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (pq[i].size() > 0 && !hold[i]) begin
        s_tvalid[i]       = 1'b1;
        s_tdata[i*W +: W] = enc(i, pid[i], cur_beat[i], pq[i][0]);
        s_tlast[i]        = (cur_beat[i] == pq[i][0] - 1);
      end else begin
        s_tvalid[i]       = 1'b0;
        s_tdata[i*W +: W] = '0;
        s_tlast[i]        = 1'b0;
      end
    end
    if (mrdy_pat.size() > 0) m_tready = (mrdy_pat.pop_front() != 0);
    else m_tready = mrdy_dflt;
  endtask

  task automatic sb_beat(input logic [31:0] d, input logic last);
    int p;
    int l;
    logic [31:0] e;
    p = int'(d[31:24]) % NP;
    l = int'(d[7:0]);
    if (open_p < 0) begin
      e = enc(p, out_pid[p], 0, l);
      open_p = p;
      open_len = l;
      out_beat = 0;
    end else begin
      e = enc(open_p, out_pid[open_p], out_beat, open_len);
    end
    check("sb_beat", d, e);
    out_beat++;
    check("sb_tlast", last, (out_beat == open_len));
    if (out_beat >= open_len) begin
      out_pid[open_p]++;
      open_p = -1;
    end
    nbeats++;
  endtask

  task automatic cycle();
    logic [NP-1:0] hs;
    drive();
    @(negedge clk);
    hs         = s_tvalid & s_tready;
    smp_busy   = busy;
    smp_gnt    = gidx;
    smp_sready = s_tready;
    smp_mvalid = m_tvalid;
    busy_log.push_back(busy);
    if (busy) begin
      if ((s_tready & ~(NP'(1) << gidx)) != '0) viol++;
      if (s_tready[gidx] !== m_tready || m_tvalid !== s_tvalid[gidx]) viol++;
      if (m_tvalid && m_tdata !== s_tdata[int'(gidx)*W +: W]) viol++;
    end else if (m_tvalid || s_tready != '0) begin
      viol++;
    end
    if (m_tvalid && m_tready) begin
      acc.push_back('{m_tdata, cyc, int'(gidx)});
      if (sb_en) sb_beat(m_tdata, m_tlast);
    end
    if (sb_en && busy && !prev_busy) begin
      for (int q = 0; q < NP; q++) begin
        if (q != int'(gidx) && prev_svalid[q]) begin
          wait_cnt[q]++;
          if (wait_cnt[q] > NP - 1) starve++;
        end
      end
      wait_cnt[gidx] = 0;
    end
    prev_busy   = busy;
    prev_svalid = s_tvalid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (hs[i] && pq[i].size() > 0) begin
        cur_beat[i]++;
        if (cur_beat[i] >= pq[i][0]) begin
          void'(pq[i].pop_front());
          cur_beat[i] = 0;
          pid[i]++;
        end
      end
    end
    cyc++;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NP; i++) begin
      pq[i].delete();
      cur_beat[i] = 0;
      pid[i]      = 0;
      hold[i]     = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_sources();
    mrdy_pat.delete();
    mrdy_dflt = 1'b1;
    sb_en     = 1'b0;
    rst       = 1'b1;
    cycle();
    rst       = 1'b0;
    acc.delete();
    busy_log.delete();
    cyc       = 0;
    viol      = 0;
  endtask

  task automatic check_beats(input string sc);
    check({sc, "_nbeats"}, acc.size(), exp_p.size());
    for (int k = 0; k < exp_p.size() && k < acc.size(); k++) begin
      check($sformatf("%s_b%0d_port", sc, k), acc[k].d[31:24], exp_p[k]);
      check($sformatf("%s_b%0d_idx", sc, k), acc[k].d[15:8], exp_b[k]);
      check($sformatf("%s_b%0d_cyc", sc, k), acc[k].c, exp_c[k]);
      check($sformatf("%s_b%0d_gnt", sc, k), acc[k].g, exp_p[k]);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    bit drained;
    rst = 1'b1; s_tdata = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b0;
    mrdy_dflt = 1'b1; sb_en = 1'b0; open_p = -1; prev_busy = 1'b0; prev_svalid = '0;
    nbeats = 0; starve = 0;
    for (int i = 0; i < NP; i++) begin
      out_pid[i] = 0; sent_pkts[i] = 0; wait_cnt[i] = 0;
    end
    @(posedge clk);
    #1;

    // Scenario 1: all ports hold 2-beat packets, port 0 has a second one.
    do_reset();
    pq[0] = '{2, 2}; pq[1] = '{2}; pq[2] = '{2}; pq[3] = '{2};
    cycle();
    check("rst_busy", smp_busy, 0);
    check("rst_mvalid", smp_mvalid, 0);
    check("rst_sready", smp_sready, 0);
    check("rst_gnt", smp_gnt, 0);
    repeat (15) cycle();
    exp_p = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    exp_b = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    exp_c = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};
    check_beats("s1");
    check("s1_excl", viol, 0);

    // Scenario 2: three single-beat packets from port 2 only.
    do_reset();
    pq[2] = '{1, 1, 1};
    repeat (7) cycle();
    exp_p = '{2, 2, 2};
    exp_b = '{0, 0, 0};
    exp_c = '{1, 3, 5};
    check_beats("s2");
    for (int k = 0; k < 3 && k < acc.size(); k++)
      check($sformatf("s2_pid%0d", k), acc[k].d[23:16], k);
    for (int k = 0; k < 7; k++)
      check($sformatf("s2_busy%0d", k), busy_log[k], k % 2);
    check("s2_excl", viol, 0);

    // Scenario 3: 4-beat packet from port 1 under toggling backpressure, port 3 waiting.
    do_reset();
    pq[1] = '{4}; pq[3] = '{1};
    mrdy_pat = '{1, 1, 0, 1, 0, 1, 0, 1};
    repeat (3) cycle();
    check("s3_stall_mvalid", smp_mvalid, 1);
    check("s3_stall_sready", smp_sready, 0);
    repeat (8) cycle();
    exp_p = '{1, 1, 1, 1, 3};
    exp_b = '{0, 1, 2, 3, 0};
    exp_c = '{1, 3, 5, 7, 9};
    check_beats("s3");
    check("s3_excl", viol, 0);

    // Scenario 4: port 0 drops tvalid for 5 cycles mid-packet, port 1 requesting.
    do_reset();
    pq[0] = '{3}; pq[1] = '{1};
    repeat (2) cycle();
    hold[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("s4_gap%0d_busy", k), smp_busy, 1);
      check($sformatf("s4_gap%0d_gnt", k), smp_gnt, 0);
      check($sformatf("s4_gap%0d_rdy1", k), smp_sready[1], 0);
    end
    hold[0] = 1'b0;
    repeat (5) cycle();
    exp_p = '{0, 0, 0, 1};
    exp_b = '{0, 1, 2, 0};
    exp_c = '{1, 7, 8, 10};
    check_beats("s4");
    check("s4_excl", viol, 0);

    // Scenario 5: reset on beat 2 of a 4-beat packet from port 2.
    do_reset();
    pq[2] = '{4};
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_sources();
    pq[2] = '{1}; pq[3] = '{1};
    cycle();
    check("s5_busy", smp_busy, 0);
    check("s5_mvalid", smp_mvalid, 0);
    check("s5_gnt_rst", smp_gnt, 0);
    cycle();
    check("s5_busy_g", smp_busy, 1);
    check("s5_gnt_p2", smp_gnt, 2);
    repeat (2) cycle();
    check("s5_gnt_p3", smp_gnt, 3);

    // Scenario 6: random packets, gaps and backpressure with a scoreboard.
    do_reset();
    sb_en = 1'b1; open_p = -1; nbeats = 0; starve = 0; prev_busy = 1'b0;
    for (int i = 0; i < NP; i++) begin
      out_pid[i] = 0; sent_pkts[i] = 0; wait_cnt[i] = 0;
    end
    guard = 0;
    while (nbeats < 10000 && guard < 60000) begin
      for (int i = 0; i < NP; i++) begin
        if (pq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          pq[i].push_back(int'($urandom_range(1, 4)));
          sent_pkts[i]++;
        end
        hold[i] = (cur_beat[i] > 0) && ($urandom_range(0, 3) == 0);
      end
      mrdy_dflt = ($urandom_range(0, 3) != 0);
      cycle();
      guard++;
    end
    check("s6_budget", guard < 60000, 1);
    for (int i = 0; i < NP; i++) hold[i] = 1'b0;
    mrdy_dflt = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 400 && !drained; k++) begin
      cycle();
      drained = 1'b1;
      for (int i = 0; i < NP; i++) if (pq[i].size() != 0) drained = 1'b0;
    end
    check("s6_drained", drained, 1);
    for (int i = 0; i < NP; i++)
      check($sformatf("s6_pkts_p%0d", i), out_pid[i], sent_pkts[i]);
    check("s6_open_pkt", open_p, -1);
    check("s6_starve", starve, 0);
    check("s6_excl", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
